shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one 32-bit shift datapath (SLL, SRL, SRA, each producing a high word and a low word) between two requesters. Each requester issues through its own valid/ready port. A round-robin grant selects one requester per cycle, the shift is computed, and the result is registered. The result returns on a single response port tagged with the requester ID. The block sits between the two issue stages and the shared shift resource.

## Interface
Parameters:
- `WIDTH`, 32: operand and result word width.
- `SH_BITS`, 5: number of low bits of `b` used as the shift amount; equals log2(WIDTH).

Ports:
- `clock`  in  1  system clock; rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted this cycle, per requester.
- `req_op0`, `req_op1`  in  2 each  operation code: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- `req_a0`, `req_a1`  in  WIDTH each  operand to be shifted.
- `req_b0`, `req_b1`  in  WIDTH each  shift amount; only `b[SH_BITS-1:0]` is used.
- `rsp_valid`  out  1  response holds a valid result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_err`  out  1  illegal op code was issued.
- `rsp_high`  out  WIDTH  high result word.
- `rsp_low`  out  WIDTH  low result word.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

## Operation
- **States:**
  - EMPTY: no result held.
  - FULL: result held, `rsp_valid`=1.
- **Slot free:** `free = EMPTY | rsp_ready`.
- **Grant:**
  - Grant goes to the only valid requester when one is valid.
  - When both are valid, grant goes to `~last`, where `last` is the last requester granted.
  - `req_ready[i] = free & grant==i`. At most one bit of `req_ready` is high per cycle.
  - `last` updates on every accepted request.
- **Transitions:**
  - EMPTY→FULL on accept.
  - FULL→FULL when accept and `rsp_ready` occur together (back-to-back).
  - FULL→EMPTY when `rsp_ready` is high and nothing is accepted.
  - FULL holds while `rsp_ready`=0. All `rsp_*` outputs are stable while held.
- **Arithmetic** (sh = `b[4:0]`; bits `b[31:5]` are ignored):
  - SLL: {high,low} = {32'b0, a} << sh. High word holds the bits shifted out.
  - SRL: low = a >> sh; high = 0.
  - SRA: low = a >>> sh (sign fill from `a[31]`); high = 32 copies of `low[31]`.
  - Illegal op (11): high = low = 0; `rsp_err`=1.
- **Reset:**
  - All outputs are 0, state is EMPTY, and `last` = 1, so requester 0 wins the first contention.
  - Reset asserted mid-operation discards the held result; nothing is replayed.

## Timing
- Latency: request accepted at edge N; response visible after edge N, in the cycle between edges N and N+1.
- Throughput: one result per cycle while `rsp_ready` stays high.
- No combinational path from `req_*` to `rsp_*`.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
- A requester must hold `req_valid` and its operands stable until `req_ready`. The block does not check this.
- A request not granted stays pending. Under continuous contention, each requester waits at most one extra cycle.
- Deassertion of `reset_n` is synchronized externally; the block only requires asynchronous assertion.

## Structure
- Package `shift_pkg`:
  - op-code constants `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ILL`;
  - typedef `shift_op_t`;
  - `WIDTH` and `SH_BITS` defaults.
- Sub-module `shift_core`:
  - purely combinational;
  - inputs: op, a, sh;
  - outputs: high, low, err;
  - instantiated once, after the grant mux.
- Top level: grant/round-robin logic, operand mux, the two-state FSM, and output registers.

## Test plan
- **SRA, req0 only.** op=10, a=0x80000000, b=4 → one cycle later: `rsp_id`=0, low=0xF8000000, high=0xFFFFFFFF, err=0.
- **SLL, req1 only.** op=00, a=0x80000001, b=0x21 (sh=1) → low=0x00000002, high=0x00000001, `rsp_id`=1.
- **Contention.** Both valid every cycle, `rsp_ready`=1 → grants alternate 0,1,0,1 from reset. `rsp_id` sequence is 0,1,0,1 with no idle cycles.
- **Back-pressure.** FULL, `rsp_ready`=0 for 3 cycles → `req_ready`=00 and `rsp_*` unchanged. `rsp_ready`=1 → the pending request is accepted in the same cycle, and the next result appears the following cycle.
- **Illegal op.** op=11, a=0x12345678 → high=low=0, err=1.
- **Reset mid-operation.** `reset_n` low while FULL → `rsp_valid`=0 immediately (asynchronous). After release, the first contended grant goes to requester 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and defaults for the two-requester shift arbiter.
package shift_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SH_BITS = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } shift_op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two valid/ready issue ports plus one tagged response port for the shift arbiter.
interface shift_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_high;
    logic [WIDTH-1:0] rsp_low;

    // Issue stages and response consumer.
    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_high, rsp_low
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_err, rsp_high, rsp_low
    );
endinterface

// File: rtl/shift_core.sv
// Combinational shifter producing a double-width result as high/low words.
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SH_BITS = DEFAULT_SH_BITS
) (
    input  shift_op_t          op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SH_BITS-1:0] sh,
    output logic [WIDTH-1:0]   high,
    output logic [WIDTH-1:0]   low,
    output logic               err
);
    logic [2*WIDTH-1:0] wide;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        high = '0;
        low  = '0;
        err  = 1'b0;
        wide = '0;
        unique case (op)
            OP_SLL: begin
                // Bits pushed past the top of a land in the high word.
                wide = {{WIDTH{1'b0}}, a} << sh;
                high = wide[2*WIDTH-1:WIDTH];
                low  = wide[WIDTH-1:0];
            end
            OP_SRL: low = a >> sh;
            OP_SRA: begin
                low  = $signed(a) >>> sh;
                high = {WIDTH{low[WIDTH-1]}};
            end
            OP_ILL: err = 1'b1;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters with a one-entry registered response.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SH_BITS = DEFAULT_SH_BITS
) (
    input  logic           clock,
    input  logic           reset_n,
    shift_arbiter_if.slave bus
);
    slot_state_t        state;
    logic               last;
    logic               grant;
    logic               free;
    logic               accept;
    shift_op_t          op_sel;
    logic [WIDTH-1:0]   a_sel;
    logic [SH_BITS-1:0] sh_sel;
    logic [WIDTH-1:0]   core_high;
    logic [WIDTH-1:0]   core_low;
    logic               core_err;

    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic               rsp_err_q;
    logic [WIDTH-1:0]   rsp_high_q;
    logic [WIDTH-1:0]   rsp_low_q;

    // Only the low SH_BITS of each shift amount matter.
    logic unused_b;
    assign unused_b = ^{bus.req_b0[WIDTH-1:SH_BITS], bus.req_b1[WIDTH-1:SH_BITS]};

    always_comb begin
        if (&bus.req_valid) grant = ~last;
        else                grant = bus.req_valid[1];
        free   = (state == EMPTY) || bus.rsp_ready;
        accept = free && (|bus.req_valid);
        bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
        op_sel = shift_op_t'(grant ? bus.req_op1 : bus.req_op0);
        a_sel  = grant ? bus.req_a1 : bus.req_a0;
        sh_sel = grant ? bus.req_b1[SH_BITS-1:0] : bus.req_b0[SH_BITS-1:0];
    end

    shift_core #(
        .WIDTH  (WIDTH),
        .SH_BITS(SH_BITS)
    ) u_core (
        .op  (op_sel),
        .a   (a_sel),
        .sh  (sh_sel),
        .high(core_high),
        .low (core_low),
        .err (core_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            last        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_high_q  <= '0;
            rsp_low_q   <= '0;
        end else if (accept) begin
            state       <= FULL;
            last        <= grant;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant;
            rsp_err_q   <= core_err;
            rsp_high_q  <= core_high;
            rsp_low_q   <= core_low;
        end else if (state == FULL && bus.rsp_ready) begin
            state       <= EMPTY;
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_high  = rsp_high_q;
    assign bus.rsp_low   = rsp_low_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: arithmetic, round-robin order, back-pressure and async reset.
module tb_shift_arbiter;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    shift_arbiter_if #(.WIDTH(32)) bus ();

    shift_arbiter #(.WIDTH(32), .SH_BITS(5)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_op0 = 2'b00; bus.req_op1 = 2'b00;
        bus.req_a0 = '0;     bus.req_a1 = '0;
        bus.req_b0 = '0;     bus.req_b1 = '0;
        bus.rsp_ready = 1'b1;
        #12;
        check("reset_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_high",  64'(bus.rsp_high),  64'd0);
        check("reset_low",   64'(bus.rsp_low),   64'd0);
        check("reset_id_err", 64'({bus.rsp_id, bus.rsp_err}), 64'd0);
        check("reset_ready", 64'(bus.req_ready), 64'd0);
        reset_n = 1'b1;

        // SRA from requester 0 alone
        bus.req_valid = 2'b01; bus.req_op0 = 2'b10;
        bus.req_a0 = 32'h8000_0000; bus.req_b0 = 32'd4;
        #1 check("sra_ready", 64'(bus.req_ready), 64'b01);
        step();
        check("sra_valid", 64'(bus.rsp_valid), 64'd1);
        check("sra_id",    64'(bus.rsp_id),    64'd0);
        check("sra_low",   64'(bus.rsp_low),   64'hF800_0000);
        check("sra_high",  64'(bus.rsp_high),  64'hFFFF_FFFF);
        check("sra_err",   64'(bus.rsp_err),   64'd0);
        bus.req_valid = 2'b00;
        #1 check("idle_ready", 64'(bus.req_ready), 64'd0);
        step();
        check("drain_valid", 64'(bus.rsp_valid), 64'd0);

        // SLL from requester 1 alone; b=0x21 shifts by 1
        bus.req_valid = 2'b10; bus.req_op1 = 2'b00;
        bus.req_a1 = 32'h8000_0001; bus.req_b1 = 32'h21;
        #1 check("sll_ready", 64'(bus.req_ready), 64'b10);
        step();
        check("sll_id",   64'(bus.rsp_id),   64'd1);
        check("sll_low",  64'(bus.rsp_low),  64'h0000_0002);
        check("sll_high", 64'(bus.rsp_high), 64'h0000_0001);

        // Contention: req0 SRL 0xF0>>4 = 0xF, req1 SRL 0x100>>8 = 0x1
        bus.req_valid = 2'b11;
        bus.req_op0 = 2'b01; bus.req_a0 = 32'h0000_00F0; bus.req_b0 = 32'd4;
        bus.req_op1 = 2'b01; bus.req_a1 = 32'h0000_0100; bus.req_b1 = 32'd8;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_ready", 64'(bus.req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            step();
            check("rr_valid", 64'(bus.rsp_valid), 64'd1);
            check("rr_id",    64'(bus.rsp_id),    64'(i % 2));
            check("rr_low",   64'(bus.rsp_low),   (i % 2 == 0) ? 64'hF : 64'h1);
        end

        // Back-pressure: hold the requester-1 result for three cycles
        bus.rsp_ready = 1'b0;
        #1 check("bp_ready", 64'(bus.req_ready), 64'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready_hold", 64'(bus.req_ready), 64'b00);
            check("bp_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_low}),
                  64'({1'b1, 1'b1, 1'b0, 32'h1}));
            check("bp_high", 64'(bus.rsp_high), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        #1 check("bp_release_ready", 64'(bus.req_ready), 64'b01);
        step();
        check("bp_next_id",  64'(bus.rsp_id),  64'd0);
        check("bp_next_low", 64'(bus.rsp_low), 64'hF);

        // Illegal op
        bus.req_valid = 2'b01; bus.req_op0 = 2'b11;
        bus.req_a0 = 32'h1234_5678; bus.req_b0 = 32'd3;
        step();
        check("ill_valid", 64'(bus.rsp_valid), 64'd1);
        check("ill_err",   64'(bus.rsp_err),   64'd1);
        check("ill_high",  64'(bus.rsp_high),  64'd0);
        check("ill_low",   64'(bus.rsp_low),   64'd0);

        // Asynchronous reset while FULL, then contention must favour requester 0
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("arst_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_err", 64'(bus.rsp_err), 64'd0);
        #2 reset_n = 1'b1;
        bus.rsp_ready = 1'b1; bus.req_valid = 2'b11;
        bus.req_op0 = 2'b00; bus.req_a0 = 32'h1; bus.req_b0 = 32'd31;
        #1 check("post_rst_ready", 64'(bus.req_ready), 64'b01);
        step();
        check("post_rst_id",   64'(bus.rsp_id),   64'd0);
        check("post_rst_low",  64'(bus.rsp_low),  64'h8000_0000);
        check("post_rst_next", 64'(bus.req_ready), 64'b10);
        bus.req_valid = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
